// File: rtl/alu_shift_unit.sv
// alu_shift_unit: multi-cycle shift/rotate engine for the ALU.
// Handles shr, shra, shl, ror and rol one position per SHIFT cycle, using the
// ALU's start/finished handshake so the datapath can hold until completion.
// Optional build macro: ALU_SHIFT_FAST4_EN -- while at least four positions
// remain, shift by four per cycle. Results are identical; only latency changes.
module alu_shift_unit #(
  parameter int WIDTH    = 32,
  parameter int AMT_BITS = 5
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             finished
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  localparam logic [AMT_BITS-1:0] CNT_ONE = AMT_BITS'(1);
`ifdef ALU_SHIFT_FAST4_EN
  localparam logic [AMT_BITS-1:0] CNT_FOUR = AMT_BITS'(4);
`endif

  state_t              state;
  logic [WIDTH-1:0]    acc;
  logic [AMT_BITS-1:0] cnt;
  logic [2:0]          op_r;
  logic [WIDTH-1:0]    acc_next;
  logic [AMT_BITS-1:0] cnt_next;
  logic                is_pass;

  // Only the low AMT_BITS of B form the shift amount; the rest is don't-care.
  logic unused_b_hi;
  assign unused_b_hi = ^B[WIDTH-1:AMT_BITS];

  // Codes above rol leave the operand untouched.
  assign is_pass = (op > OP_ROL);

  // One-position shift/rotate with the per-op fill bit.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       o);
    case (o)
      OP_SHR:  shift_one = {1'b0, v[WIDTH-1:1]};
      OP_SHRA: shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SHL:  shift_one = {v[WIDTH-2:0], 1'b0};
      OP_ROR:  shift_one = {v[0], v[WIDTH-1:1]};
      OP_ROL:  shift_one = {v[WIDTH-2:0], v[WIDTH-1]};
      default: shift_one = v;
    endcase
  endfunction

  // Next accumulator/count for one SHIFT cycle (by 1, or by 4 in the fast build).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_next = shift_one(acc, op_r);
    cnt_next = cnt - CNT_ONE;
`ifdef ALU_SHIFT_FAST4_EN
    if (cnt >= CNT_FOUR) begin
      acc_next = shift_one(shift_one(shift_one(shift_one(acc, op_r), op_r), op_r), op_r);
      cnt_next = cnt - CNT_FOUR;
    end
`endif
  end

  // Control FSM with registered busy/finished. The finished pulse is issued
  // on the DONE->IDLE edge, so busy stays high alongside it; IDLE drops both a
  // cycle later and only accepts a new start once busy has fallen.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      op_r     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (busy) begin
            busy     <= 1'b0;
            finished <= 1'b0;
          end else if (start) begin
            acc   <= A;
            cnt   <= is_pass ? '0 : B[AMT_BITS-1:0];
            op_r  <= op;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            result <= acc;
            state  <= DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt_next;
          end
        end
        DONE: begin
          finished <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_unit.sv
// tb_alu_shift_unit: directed and randomized checks of alu_shift_unit against
// an arithmetic reference model (shift operators on whole words).
module tb_alu_shift_unit;

  logic        Clock = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        busy;
  logic        finished;

  int checks = 0;
  int errors = 0;

  alu_shift_unit #(.WIDTH(32), .AMT_BITS(5)) dut (
    .Clock    (Clock),
    .clear    (clear),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .result   (result),
    .busy     (busy),
    .finished (finished)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: whole-word shifts; rotates built from two opposite shifts.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input int n);
    logic [31:0] r;
    case (o)
      3'd0:    r = a >> n;
      3'd1:    r = $signed(a) >>> n;
      3'd2:    r = a << n;
      3'd3:    r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      3'd4:    r = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic int latency(input int n);
`ifdef ALU_SHIFT_FAST4_EN
    return n / 4 + n % 4 + 2;
`else
    return n + 2;
`endif
  endfunction

  // Called at a negedge; issues one operation and follows it to completion.
  // Returns at the negedge after busy falls, so a follow-on call exercises the
  // earliest accepted restart.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int          n;
    int          lat;
    int          fin_k;
    int          pulses;
    int          busy_bad;
    logic [31:0] exp;
    logic [31:0] res_at_fin;
    n   = (o > 3'd4) ? 0 : int'(b[4:0]);
    exp = ref_model(o, a, n);
    lat = latency(n);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge Clock);  // E0
    fin_k = -1; pulses = 0; busy_bad = 0; res_at_fin = 'x;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge Clock);  // sampling point after edge E0+k
      if (k == 0) begin
        start = 1'b0;
        op = 3'($urandom); A = $urandom; B = $urandom;
      end
      if (finished) begin
        pulses++;
        if (fin_k < 0) begin
          fin_k      = k;
          res_at_fin = result;
        end
      end
      if (busy !== (k <= lat)) busy_bad++;
    end
    check({tag, ".result"}, res_at_fin, exp);
    check({tag, ".fin_cycle"}, 32'(fin_k), 32'(lat));
    check({tag, ".fin_pulses"}, 32'(pulses), 32'd1);
    check({tag, ".busy_shape"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          fin_seen;
    clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    @(negedge Clock);
    @(negedge Clock);
    clear = 1'b0;
    check("rst.result", result, 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.finished", 32'(finished), 32'h0);

    // Directed cases.
    run_op("shl3",  3'b010, 32'h0000_0002, 32'd3);
    run_op("shra4", 3'b001, 32'h8000_0000, 32'd4);
    run_op("shr4",  3'b000, 32'h8000_0000, 32'd4);
    run_op("ror1",  3'b011, 32'h0000_0001, 32'd1);
    run_op("rol33", 3'b100, 32'h8000_0001, 32'h0000_0021);
    run_op("shl0",  3'b010, 32'h1234_5678, 32'd0);
    run_op("pass7", 3'b111, 32'h1234_5678, 32'd9);
    run_op("ror31", 3'b011, 32'hA5A5_0F0F, 32'd31);
    run_op("shra31", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF);

    // Result holds while idle even with moving inputs.
    held = result;
    for (int i = 0; i < 5; i++) begin
      op = 3'($urandom); A = $urandom; B = $urandom;
      @(negedge Clock);
    end
    check("hold.result", result, held);
    check("hold.busy", 32'(busy), 32'h0);

    // Abort: start ignored mid-shift, clear abandons the operation.
    op = 3'b010; A = 32'd1; B = 32'd20; start = 1'b1;
    @(posedge Clock);  // E0
    @(negedge Clock);  // after E0
    start = 1'b0;
    @(negedge Clock);  // after E0+1
    @(negedge Clock);  // after E0+2
    start = 1'b1; A = 32'hFFFF_FFFF; B = 32'd0;  // sampled at E0+3
    @(negedge Clock);
    start = 1'b0;
    @(negedge Clock);  // after E0+4
    @(negedge Clock);  // after E0+5
    check("abort.busy_before", 32'(busy), 32'h1);
    check("abort.fin_before", 32'(finished), 32'h0);
    clear = 1'b1;      // sampled at E0+6
    @(negedge Clock);
    clear = 1'b0;
    check("abort.busy", 32'(busy), 32'h0);
    check("abort.result", result, 32'h0);
    fin_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (finished || busy) fin_seen++;
      @(negedge Clock);
    end
    check("abort.quiet", 32'(fin_seen), 32'h0);
    run_op("restart2", 3'b010, 32'd1, 32'd2);

    // Randomized operations, back to back, with biased amounts.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] b;
      b = $urandom;
      if (i % 7 == 0) b[4:0] = 5'd0;
      if (i % 11 == 0) b[4:0] = 5'd31;
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), $urandom, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
